// File: rtl/ucode_sequencer.sv
// Next-address controller for the microcode ROM: computes the ROM address each cycle
// from the current microword's sequencing fields, with a small call/return stack.
module ucode_sequencer #(
  parameter int UCODE_ADDR_LENGTH = 10,
  parameter int STACK_DEPTH       = 4,
  parameter int RESET_ADDR        = 0,
  parameter int FETCH_ADDR        = 1,
  parameter int IRQ_ADDR          = 2,
  parameter int DISPATCH_BASE     = 256
) (
  input  logic                         clk_i,
  input  logic                         reset_ni,
  output logic [UCODE_ADDR_LENGTH-1:0] ucode_addr_o,
  input  logic [2:0]                   seq_op_i,
  input  logic [UCODE_ADDR_LENGTH-1:0] seq_target_i,
  input  logic [2:0]                   seq_cond_sel_i,
  input  logic [7:0]                   cond_flags_i,
  input  logic [7:0]                   opcode_i,
  input  logic                         stall_i,
  input  logic                         irq_i,
  output logic                         irq_ack_o,
  output logic                         seq_valid_o,
  output logic                         seq_error_o
);

  localparam int AW  = UCODE_ADDR_LENGTH;
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [AW-1:0]  RESET_A   = AW'(RESET_ADDR);
  localparam logic [AW-1:0]  FETCH_A   = AW'(FETCH_ADDR);
  localparam logic [AW-1:0]  IRQ_A     = AW'(IRQ_ADDR);
  localparam logic [AW-1:0]  DISP_BASE = AW'(DISPATCH_BASE);
  localparam logic [SPW-1:0] SP_FULL   = SPW'(STACK_DEPTH);
  localparam logic [SPW-1:0] SP_ONE    = SPW'(1);

  localparam logic [2:0] OP_NEXT     = 3'd0;
  localparam logic [2:0] OP_JUMP     = 3'd1;
  localparam logic [2:0] OP_JUMPC    = 3'd2;
  localparam logic [2:0] OP_CALL     = 3'd3;
  localparam logic [2:0] OP_RET      = 3'd4;
  localparam logic [2:0] OP_DISPATCH = 3'd5;
  localparam logic [2:0] OP_WAIT     = 3'd6;
  localparam logic [2:0] OP_FETCH   = 3'd7;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } seqState_e;

  seqState_e         state_q, state_d;
  logic [AW-1:0]     pc_q, pc_d;
  logic [SPW-1:0]    sp_q, sp_d;
  logic [AW-1:0]     stack_q [STACK_DEPTH];

  logic              condBit;
  logic [AW-1:0]     pcPlus1;
  logic [AW-1:0]     dispAddr;
  logic [AW-1:0]     stackTop;
  logic [IW-1:0]     pushIdx;
  logic [IW-1:0]     topIdx;
  logic              doPush;
  logic              irqAck;
  logic              seqValid;
  logic [AW-1:0]     nextAddr;

  assign condBit  = cond_flags_i[seq_cond_sel_i];
  assign pcPlus1  = pc_q + AW'(1);
  assign dispAddr = DISP_BASE + AW'(opcode_i);
  assign pushIdx  = IW'(sp_q);
  assign topIdx   = IW'(sp_q - SP_ONE);
  assign stackTop = stack_q[topIdx];

  // Next-address selection; everything defaults to "hold" so HALT and stall fall out naturally.
  always_comb begin
    state_d  = state_q;
    nextAddr = pc_q;
    sp_d     = sp_q;
    doPush   = 1'b0;
    irqAck   = 1'b0;
    seqValid = 1'b0;

    unique case (state_q)
      S_BOOT: begin
        nextAddr = RESET_A;
        state_d  = S_RUN;
      end

      S_RUN: begin
        seqValid = 1'b1;
        if (!stall_i) begin
          unique case (seq_op_i)
            OP_NEXT:     nextAddr = pcPlus1;
            OP_JUMP:     nextAddr = seq_target_i;
            OP_JUMPC:    nextAddr = condBit ? seq_target_i : pcPlus1;
            OP_CALL: begin
              if (sp_q < SP_FULL) begin
                doPush   = 1'b1;
                sp_d     = sp_q + SP_ONE;
                nextAddr = seq_target_i;
              end else begin
                state_d = S_HALT;
              end
            end
            OP_RET: begin
              if (sp_q != '0) begin
                sp_d     = sp_q - SP_ONE;
                nextAddr = stackTop;
              end else begin
                state_d = S_HALT;
              end
            end
            OP_DISPATCH: nextAddr = dispAddr;
            OP_WAIT:     nextAddr = condBit ? pcPlus1 : pc_q;
            OP_FETCH: begin
              if (irq_i) begin
                nextAddr = IRQ_A;
                irqAck   = 1'b1;
              end else begin
                nextAddr = FETCH_A;
              end
            end
            default:     nextAddr = pc_q;
          endcase
        end
      end

      S_HALT: nextAddr = pc_q;

      default: state_d = S_BOOT;
    endcase
  end

  assign pc_d         = nextAddr;
  assign ucode_addr_o = nextAddr;
  assign irq_ack_o    = irqAck;
  assign seq_valid_o  = seqValid;
  assign seq_error_o  = (state_q == S_HALT);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_A;
      sp_q    <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      if (doPush) begin
        stack_q[pushIdx] <= pcPlus1;
      end
    end
  end

endmodule

// File: tb/tb_ucode_sequencer.sv
// Directed-vector bench for ucode_sequencer; a second instance with DISPATCH_BASE=1000
// exercises dispatch-sum wraparound.
module tb_ucode_sequencer;

  localparam int AW = 10;

  localparam logic [2:0] OP_NEXT     = 3'd0;
  localparam logic [2:0] OP_JUMP     = 3'd1;
  localparam logic [2:0] OP_JUMPC    = 3'd2;
  localparam logic [2:0] OP_CALL     = 3'd3;
  localparam logic [2:0] OP_RET      = 3'd4;
  localparam logic [2:0] OP_DISPATCH = 3'd5;
  localparam logic [2:0] OP_WAIT     = 3'd6;
  localparam logic [2:0] OP_FETCH    = 3'd7;

  logic          clk_i = 1'b0;
  logic          reset_ni = 1'b1;
  logic [AW-1:0] ucode_addr_o;
  logic [2:0]    seq_op_i = OP_NEXT;
  logic [AW-1:0] seq_target_i = '0;
  logic [2:0]    seq_cond_sel_i = '0;
  logic [7:0]    cond_flags_i = '0;
  logic [7:0]    opcode_i = '0;
  logic          stall_i = 1'b0;
  logic          irq_i = 1'b0;
  logic          irq_ack_o;
  logic          seq_valid_o;
  logic          seq_error_o;

  logic [AW-1:0] addr2;
  logic          ack2, valid2, err2;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  ucode_sequencer #(.UCODE_ADDR_LENGTH(AW), .STACK_DEPTH(4), .RESET_ADDR(0),
                    .FETCH_ADDR(1), .IRQ_ADDR(2), .DISPATCH_BASE(256)) u_dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .ucode_addr_o(ucode_addr_o),
    .seq_op_i(seq_op_i), .seq_target_i(seq_target_i), .seq_cond_sel_i(seq_cond_sel_i),
    .cond_flags_i(cond_flags_i), .opcode_i(opcode_i), .stall_i(stall_i), .irq_i(irq_i),
    .irq_ack_o(irq_ack_o), .seq_valid_o(seq_valid_o), .seq_error_o(seq_error_o)
  );

  ucode_sequencer #(.UCODE_ADDR_LENGTH(AW), .STACK_DEPTH(4), .RESET_ADDR(0),
                    .FETCH_ADDR(1), .IRQ_ADDR(2), .DISPATCH_BASE(1000)) u_dut2 (
    .clk_i(clk_i), .reset_ni(reset_ni), .ucode_addr_o(addr2),
    .seq_op_i(seq_op_i), .seq_target_i(seq_target_i), .seq_cond_sel_i(seq_cond_sel_i),
    .cond_flags_i(cond_flags_i), .opcode_i(opcode_i), .stall_i(stall_i), .irq_i(irq_i),
    .irq_ack_o(ack2), .seq_valid_o(valid2), .seq_error_o(err2)
  );

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic drive(input logic [2:0] op, input logic [AW-1:0] tgt);
    seq_op_i     = op;
    seq_target_i = tgt;
    #1;
  endtask

  task automatic jumpTo(input logic [AW-1:0] a);
    drive(OP_JUMP, a);
    tick();
  endtask

  task automatic resetDut();
    reset_ni = 1'b0;
    #2;
    @(posedge clk_i);
    #2;
    reset_ni = 1'b1;
    #1;
    tick();
  endtask

  task automatic test_reset();
    #1 reset_ni = 1'b0;
    #2;
    total++; if (ucode_addr_o !== 10'd0) begin bad++; $display("[TB] FAIL reset_addr got=%0d exp=0", ucode_addr_o); end
    total++; if (seq_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b exp=0", seq_valid_o); end
    total++; if (seq_error_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_error got=%b exp=0", seq_error_o); end
    total++; if (irq_ack_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_ack got=%b exp=0", irq_ack_o); end
    @(posedge clk_i);
    #2 reset_ni = 1'b1;
    #1;
    total++; if (ucode_addr_o !== 10'd0) begin bad++; $display("[TB] FAIL boot_addr got=%0d exp=0", ucode_addr_o); end
    total++; if (seq_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL boot_valid got=%b exp=0", seq_valid_o); end
    tick();
    drive(OP_NEXT, '0);
    total++; if (ucode_addr_o !== 10'd1) begin bad++; $display("[TB] FAIL next_1 got=%0d exp=1", ucode_addr_o); end
    total++; if (seq_valid_o !== 1'b1) begin bad++; $display("[TB] FAIL run_valid got=%b exp=1", seq_valid_o); end
    tick();
    total++; if (ucode_addr_o !== 10'd2) begin bad++; $display("[TB] FAIL next_2 got=%0d exp=2", ucode_addr_o); end
    tick();
    total++; if (ucode_addr_o !== 10'd3) begin bad++; $display("[TB] FAIL next_3 got=%0d exp=3", ucode_addr_o); end
  endtask

  task automatic test_jumpc();
    jumpTo(10'd10);
    seq_cond_sel_i = 3'd3;
    cond_flags_i   = 8'h08;
    drive(OP_JUMPC, 10'd40);
    total++; if (ucode_addr_o !== 10'd40) begin bad++; $display("[TB] FAIL jumpc_taken got=%0d exp=40", ucode_addr_o); end
    cond_flags_i = 8'h00;
    #1;
    total++; if (ucode_addr_o !== 10'd11) begin bad++; $display("[TB] FAIL jumpc_not_taken got=%0d exp=11", ucode_addr_o); end
    cond_flags_i = 8'hF7;
    #1;
    total++; if (ucode_addr_o !== 10'd11) begin bad++; $display("[TB] FAIL jumpc_other_bits got=%0d exp=11", ucode_addr_o); end
    tick();
    drive(OP_NEXT, '0);
    total++; if (ucode_addr_o !== 10'd12) begin bad++; $display("[TB] FAIL jumpc_after got=%0d exp=12", ucode_addr_o); end
    cond_flags_i = 8'h00;
  endtask

  task automatic test_call_ret();
    jumpTo(10'd5);
    drive(OP_CALL, 10'd100);
    total++; if (ucode_addr_o !== 10'd100) begin bad++; $display("[TB] FAIL call_1 got=%0d exp=100", ucode_addr_o); end
    tick();
    drive(OP_CALL, 10'd200);
    total++; if (ucode_addr_o !== 10'd200) begin bad++; $display("[TB] FAIL call_2 got=%0d exp=200", ucode_addr_o); end
    tick();
    drive(OP_RET, '0);
    total++; if (ucode_addr_o !== 10'd101) begin bad++; $display("[TB] FAIL ret_1 got=%0d exp=101", ucode_addr_o); end
    tick();
    drive(OP_RET, '0);
    total++; if (ucode_addr_o !== 10'd6) begin bad++; $display("[TB] FAIL ret_2 got=%0d exp=6", ucode_addr_o); end
    tick();
    drive(OP_NEXT, '0);
    total++; if (ucode_addr_o !== 10'd7) begin bad++; $display("[TB] FAIL after_ret got=%0d exp=7", ucode_addr_o); end
  endtask

  task automatic test_overflow();
    logic [AW-1:0] tgts [4];
    tgts[0] = 10'd300; tgts[1] = 10'd310; tgts[2] = 10'd320; tgts[3] = 10'd330;
    for (int i = 0; i < 4; i++) begin
      drive(OP_CALL, tgts[i]);
      tick();
    end
    drive(OP_CALL, 10'd340);
    total++; if (ucode_addr_o !== 10'd330) begin bad++; $display("[TB] FAIL ovf_addr got=%0d exp=330", ucode_addr_o); end
    total++; if (seq_valid_o !== 1'b1) begin bad++; $display("[TB] FAIL ovf_valid got=%b exp=1", seq_valid_o); end
    total++; if (seq_error_o !== 1'b0) begin bad++; $display("[TB] FAIL ovf_err_early got=%b exp=0", seq_error_o); end
    tick();
    total++; if (ucode_addr_o !== 10'd330) begin bad++; $display("[TB] FAIL halt_addr got=%0d exp=330", ucode_addr_o); end
    total++; if (seq_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL halt_valid got=%b exp=0", seq_valid_o); end
    total++; if (seq_error_o !== 1'b1) begin bad++; $display("[TB] FAIL halt_err got=%b exp=1", seq_error_o); end
    drive(OP_NEXT, '0);
    tick();
    tick();
    total++; if (ucode_addr_o !== 10'd330) begin bad++; $display("[TB] FAIL halt_hold got=%0d exp=330", ucode_addr_o); end
    total++; if (seq_error_o !== 1'b1) begin bad++; $display("[TB] FAIL halt_sticky got=%b exp=1", seq_error_o); end
    resetDut();
  endtask

  task automatic test_underflow();
    drive(OP_RET, '0);
    total++; if (ucode_addr_o !== 10'd0) begin bad++; $display("[TB] FAIL unf_addr got=%0d exp=0", ucode_addr_o); end
    total++; if (seq_valid_o !== 1'b1) begin bad++; $display("[TB] FAIL unf_valid got=%b exp=1", seq_valid_o); end
    tick();
    total++; if (seq_error_o !== 1'b1) begin bad++; $display("[TB] FAIL unf_err got=%b exp=1", seq_error_o); end
    total++; if (seq_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL unf_halt_valid got=%b exp=0", seq_valid_o); end
    drive(OP_NEXT, '0);
    tick();
    tick();
    total++; if (seq_error_o !== 1'b1) begin bad++; $display("[TB] FAIL unf_sticky got=%b exp=1", seq_error_o); end
    total++; if (ucode_addr_o !== 10'd0) begin bad++; $display("[TB] FAIL unf_hold got=%0d exp=0", ucode_addr_o); end
    reset_ni = 1'b0;
    #1;
    total++; if (seq_error_o !== 1'b0) begin bad++; $display("[TB] FAIL unf_reset_err got=%b exp=0", seq_error_o); end
    @(posedge clk_i);
    #2 reset_ni = 1'b1;
    #1;
    total++; if (seq_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL unf_boot_valid got=%b exp=0", seq_valid_o); end
    tick();
    total++; if (ucode_addr_o !== 10'd1) begin bad++; $display("[TB] FAIL unf_restart got=%0d exp=1", ucode_addr_o); end
  endtask

  task automatic test_dispatch();
    jumpTo(10'd20);
    opcode_i = 8'h3E;
    drive(OP_DISPATCH, '0);
    total++; if (ucode_addr_o !== 10'd318) begin bad++; $display("[TB] FAIL disp_3e got=%0d exp=318", ucode_addr_o); end
    total++; if (addr2 !== 10'd38) begin bad++; $display("[TB] FAIL disp1000_3e got=%0d exp=38", addr2); end
    opcode_i = 8'hFF;
    #1;
    total++; if (ucode_addr_o !== 10'd511) begin bad++; $display("[TB] FAIL disp_ff got=%0d exp=511", ucode_addr_o); end
    total++; if (addr2 !== 10'd231) begin bad++; $display("[TB] FAIL disp1000_ff got=%0d exp=231", addr2); end
    jumpTo(10'd1023);
    drive(OP_NEXT, '0);
    total++; if (ucode_addr_o !== 10'd0) begin bad++; $display("[TB] FAIL wrap got=%0d exp=0", ucode_addr_o); end
    tick();
    total++; if (ucode_addr_o !== 10'd1) begin bad++; $display("[TB] FAIL wrap_after got=%0d exp=1", ucode_addr_o); end
  endtask

  task automatic test_irq();
    jumpTo(10'd30);
    irq_i   = 1'b1;
    stall_i = 1'b1;
    drive(OP_FETCH, '0);
    total++; if (ucode_addr_o !== 10'd30) begin bad++; $display("[TB] FAIL stall_addr got=%0d exp=30", ucode_addr_o); end
    total++; if (irq_ack_o !== 1'b0) begin bad++; $display("[TB] FAIL stall_ack got=%b exp=0", irq_ack_o); end
    tick();
    total++; if (ucode_addr_o !== 10'd30) begin bad++; $display("[TB] FAIL stall_hold got=%0d exp=30", ucode_addr_o); end
    stall_i = 1'b0;
    #1;
    total++; if (ucode_addr_o !== 10'd2) begin bad++; $display("[TB] FAIL irq_vec got=%0d exp=2", ucode_addr_o); end
    total++; if (irq_ack_o !== 1'b1) begin bad++; $display("[TB] FAIL irq_ack got=%b exp=1", irq_ack_o); end
    tick();
    drive(OP_NEXT, '0);
    total++; if (irq_ack_o !== 1'b0) begin bad++; $display("[TB] FAIL ack_pulse got=%b exp=0", irq_ack_o); end
    total++; if (ucode_addr_o !== 10'd3) begin bad++; $display("[TB] FAIL irq_after got=%0d exp=3", ucode_addr_o); end
    irq_i = 1'b0;
    drive(OP_FETCH, '0);
    total++; if (ucode_addr_o !== 10'd1) begin bad++; $display("[TB] FAIL fetch got=%0d exp=1", ucode_addr_o); end
    total++; if (irq_ack_o !== 1'b0) begin bad++; $display("[TB] FAIL fetch_ack got=%b exp=0", irq_ack_o); end
  endtask

  task automatic test_wait();
    jumpTo(10'd50);
    seq_cond_sel_i = 3'd0;
    cond_flags_i   = 8'hFE;
    drive(OP_WAIT, '0);
    total++; if (ucode_addr_o !== 10'd50) begin bad++; $display("[TB] FAIL wait_hold got=%0d exp=50", ucode_addr_o); end
    tick();
    total++; if (ucode_addr_o !== 10'd50) begin bad++; $display("[TB] FAIL wait_hold2 got=%0d exp=50", ucode_addr_o); end
    total++; if (seq_valid_o !== 1'b1) begin bad++; $display("[TB] FAIL wait_valid got=%b exp=1", seq_valid_o); end
    cond_flags_i = 8'h01;
    #1;
    total++; if (ucode_addr_o !== 10'd51) begin bad++; $display("[TB] FAIL wait_go got=%0d exp=51", ucode_addr_o); end
    tick();
    drive(OP_NEXT, '0);
    total++; if (ucode_addr_o !== 10'd52) begin bad++; $display("[TB] FAIL wait_after got=%0d exp=52", ucode_addr_o); end
    cond_flags_i = 8'h00;
  endtask

  task automatic test_back_to_back();
    jumpTo(10'd60);
    stall_i = 1'b1;
    drive(OP_CALL, 10'd400);
    total++; if (ucode_addr_o !== 10'd60) begin bad++; $display("[TB] FAIL stall_call got=%0d exp=60", ucode_addr_o); end
    tick();
    stall_i = 1'b0;
    #1;
    total++; if (ucode_addr_o !== 10'd400) begin bad++; $display("[TB] FAIL call_release got=%0d exp=400", ucode_addr_o); end
    tick();
    drive(OP_RET, '0);
    total++; if (ucode_addr_o !== 10'd61) begin bad++; $display("[TB] FAIL b2b_ret got=%0d exp=61", ucode_addr_o); end
    tick();
    total++; if (seq_error_o !== 1'b0) begin bad++; $display("[TB] FAIL b2b_noerr got=%b exp=0", seq_error_o); end
    tick();
    total++; if (seq_error_o !== 1'b1) begin bad++; $display("[TB] FAIL b2b_single_push got=%b exp=1", seq_error_o); end
  endtask

  initial begin
    test_reset();
    test_jumpc();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_dispatch();
    test_irq();
    test_wait();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ucode_sequencer.md
# ucode_sequencer

- Next-address controller for the microcode ROM.
- Each cycle it computes the ROM address from the sequencing fields of the microword currently on the ROM output. Those inputs are condition flags, the fetched opcode, stall and interrupt request.
- The ROM registers that address, so one microinstruction retires per cycle.
- It holds a small call/return stack and a boot/run/halt state machine.

## Interface
Parameters:
- UCODE_ADDR_LENGTH, 10, microcode address width (AW)
- STACK_DEPTH, 4, call-stack entries (≥1)
- RESET_ADDR, 0, first microword executed after reset
- FETCH_ADDR, 1, opcode-fetch routine entry
- IRQ_ADDR, 2, interrupt routine entry
- DISPATCH_BASE, 256, base of the opcode dispatch table

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low (asserted when 0)
- ucode_addr  out  AW  address to ROM, combinational from state
- seq_op  in  3  microword sequencing op:
  - 0 NEXT, 1 JUMP, 2 JUMPC, 3 CALL
  - 4 RET, 5 DISPATCH, 6 WAIT, 7 FETCH
- seq_target  in  AW  microword branch/call target
- seq_cond_sel  in  3  selects bit of cond_flags
- cond_flags  in  8  datapath condition bits
- opcode  in  8  current instruction opcode
- stall  in  1  freeze sequencing this cycle
- irq  in  1  level interrupt request
- irq_ack  out  1  one-cycle pulse when IRQ vector taken
- seq_valid  out  1  ROM output holds a word the sequencer issued
- seq_error  out  1  sticky stack overflow/underflow flag

## Operation
Internal registers:
- pc: address of the word currently on the ROM output
- state: BOOT / RUN / HALT
- stack[STACK_DEPTH], sp (0..STACK_DEPTH)

Let c = cond_flags[seq_cond_sel].

BOOT:
- ucode_addr = RESET_ADDR; seq_valid = 0.
- Next cycle: state = RUN, pc = RESET_ADDR.

HALT:
- ucode_addr = pc, seq_valid = 0, seq_error = 1.
- Stays in HALT until reset.

RUN, in priority order:
1. stall = 1: next = pc. No stack change, no irq_ack.
2. NEXT: next = pc+1.
3. JUMP: next = seq_target.
4. JUMPC: next = c ? seq_target : pc+1.
5. CALL:
   - sp < STACK_DEPTH: push pc+1, sp++, next = seq_target.
   - Otherwise: overflow, go to HALT, next = pc, stack unchanged.
6. RET:
   - sp > 0: next = stack top, sp--.
   - Otherwise: underflow, go to HALT, next = pc.
7. DISPATCH: next = (DISPATCH_BASE + opcode) mod 2^AW.
8. WAIT: next = c ? pc+1 : pc.
9. FETCH:
   - irq = 1: next = IRQ_ADDR, irq_ack = 1 that cycle.
   - Otherwise: next = FETCH_ADDR.

Rules in RUN:
- ucode_addr = next; pc <= next on each clk edge.
- seq_valid = 1 in RUN.

Arithmetic:
- pc+1 and dispatch sums are AW-bit and wrap modulo 2^AW; all-ones + 1 gives 0.
- Stack stores AW-bit return addresses.

## Timing
- Reset asserted (asynchronous):
  - state = BOOT, pc = RESET_ADDR, sp = 0.
  - irq_ack = 0, seq_error = 0, seq_valid = 0, ucode_addr = RESET_ADDR.
- First rising edge after reset release:
  - ROM latches RESET_ADDR; state becomes RUN.
  - On the following cycle, seq_op etc. reflect word RESET_ADDR.
- Latency: a word's sequencing fields affect ucode_addr combinationally in the same cycle. The next word appears on the ROM output one cycle later. Throughput is 1 word/cycle.
- irq_ack:
  - Combinational, high only in a RUN cycle with FETCH, irq = 1, stall = 0.
  - A stalled FETCH gives no ack; irq is re-evaluated when the stall clears.
- Stall holds ucode_addr = pc, so the ROM re-reads the same word and the fields stay stable.
- CALL and RET never occur in the same cycle (one op per word), so no simultaneous push/pop.
- The HALT transition takes effect on the next edge. The erroring cycle already drives ucode_addr = pc, with seq_valid still 1.
- Reset mid-operation (any state) clears the stack and returns to BOOT immediately.

## Test plan
- Reset then NEXT chain from RESET_ADDR=0:
  - ucode_addr = 0 in BOOT, then 1, 2, 3 on successive cycles.
  - seq_valid rises one cycle after reset release.
- JUMPC, seq_cond_sel = 3, pc = 10, target 40:
  - cond_flags = 8'h08 gives next = 40.
  - cond_flags = 0 gives next = 11.
- Nested calls and returns, STACK_DEPTH=4:
  - CALL at 5→100, CALL at 100→200, RET, RET gives ucode_addr 100, 200, 101, 6.
  - A 5th nested CALL gives seq_error = 1, ucode_addr frozen, seq_valid = 0.
- RET with empty stack → HALT, seq_error stays 1 until reset; reset clears it and restarts at RESET_ADDR.
- DISPATCH:
  - opcode 8'h3E, base 256 gives next = 318.
  - base 1000 with AW = 10, opcode 8'hFF gives (1000+255) mod 1024 = 231.
  - NEXT at pc = 1023 gives 0.
- FETCH with irq = 1:
  - stall = 1 holds ucode_addr = pc, irq_ack = 0.
  - On stall release: ucode_addr = 2, irq_ack = 1 for exactly one cycle.
  - WAIT with c = 0 holds pc until c = 1, then pc+1.
